trdb_branch_collector: RTL

- Parametrised successor to the single-lane trdb_branch_map.
- Collects branch outcomes from up to NLANES retired branches per cycle into a MAP_LEN-bit branch map.
- Hands completed or flushed maps to the packet emitter through a one-entry valid/ready output register.
- Back-pressures the retire side through ready_o, and flags lost outcomes with a sticky overflow flag.

---
 rtl/trdb_pkg.sv | 15 +
 rtl/trdb_lane_compact.sv | 26 ++
 rtl/trdb_branch_collector.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared trace-debugger types and defaults for the branch-map collector and its helpers.
package trdb_pkg;

    localparam int unsigned TRDB_BMAP_LEN_DEFAULT   = 31;
    localparam int unsigned TRDB_BMAP_LANES_DEFAULT = 2;
    localparam int unsigned TRDB_BMAP_CNT_W_DEFAULT = $clog2(TRDB_BMAP_LEN_DEFAULT + 1);

    // Branch map as handed to the packet emitter (default geometry).
    typedef struct packed {
        logic [TRDB_BMAP_LEN_DEFAULT-1:0]   map;
        logic [TRDB_BMAP_CNT_W_DEFAULT-1:0] cnt;
        logic                               full;
    } trdb_bmap_t;

endpackage

// File: rtl/trdb_lane_compact.sv
// Packs the data bits of the valid lanes into contiguous low bits, in lane order,
// and reports how many lanes were valid.
module trdb_lane_compact #(
    parameter int unsigned NLANES = 2,
    parameter int unsigned N_W    = $clog2(NLANES + 1)
) (
    input  logic [NLANES-1:0] valid,
    input  logic [NLANES-1:0] data,
    output logic [NLANES-1:0] bits,
    output logic [N_W-1:0]    n
);

    always_comb begin
        int unsigned pos;
        pos  = 0;
        bits = '0;
        for (int k = 0; k < int'(NLANES); k++) begin
            if (valid[k]) begin
                bits[pos] = data[k];
                pos       = pos + 1;
            end
        end
        n = N_W'(pos);
    end

endmodule

// File: rtl/trdb_branch_collector.sv
// Collects up to NLANES retired branch outcomes per cycle into a MAP_LEN-bit map and
// hands full or flushed maps to the emitter through a one-entry valid/ready register.
module trdb_branch_collector
    import trdb_pkg::*;
#(
    parameter int unsigned NLANES  = TRDB_BMAP_LANES_DEFAULT,
    parameter int unsigned MAP_LEN = TRDB_BMAP_LEN_DEFAULT,
    parameter int unsigned CNT_W   = $clog2(MAP_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NLANES-1:0]  valid_i,
    input  logic [NLANES-1:0]  taken_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               full_o,
    output logic               map_valid_o,
    input  logic               map_ready_i,
    output logic               overflow_o
);

    localparam int unsigned N_W   = $clog2(NLANES + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned WIDE  = MAP_LEN + NLANES;

    typedef struct packed {
        logic [MAP_LEN-1:0] map;
        logic [CNT_W-1:0]   cnt;
        logic               full;
    } bmap_t;

    logic [MAP_LEN-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]   acc_cnt_reg, acc_cnt_next;
    logic               flush_pending_reg, flush_pending_next;
    logic               overflow_reg, overflow_next;
    bmap_t              out_reg;
    logic               out_valid_reg;

    logic [NLANES-1:0]  lane_bits;
    logic [N_W-1:0]     lane_n;
    logic [SUM_W-1:0]   total;
    logic [WIDE-1:0]    merged;
    logic               out_free, room, ready;
    logic               load;
    bmap_t              load_map;

    // Trace encoding stores 1 for a NOT-taken branch.
    trdb_lane_compact #(.NLANES(NLANES), .N_W(N_W)) u_compact (
        .valid (valid_i),
        .data  (~taken_i),
        .bits  (lane_bits),
        .n     (lane_n)
    );

    assign out_free = !out_valid_reg || map_ready_i;
    assign room     = (SUM_W'(acc_cnt_reg) + SUM_W'(NLANES)) < SUM_W'(MAP_LEN);
    assign ready    = !flush_pending_reg && (room || out_free);
    assign total    = SUM_W'(acc_cnt_reg) + SUM_W'(lane_n);
    assign merged   = WIDE'(acc_reg) | (WIDE'(lane_bits) << acc_cnt_reg);

    always_comb begin
        acc_next           = acc_reg;
        acc_cnt_next       = acc_cnt_reg;
        flush_pending_next = flush_pending_reg;
        overflow_next      = overflow_reg;
        load               = 1'b0;
        load_map           = '0;
        if (ready) begin
            if (total >= SUM_W'(MAP_LEN)) begin
                // Completed map; any spill lanes seed the next accumulator.
                load               = 1'b1;
                load_map           = '{map: merged[MAP_LEN-1:0], cnt: CNT_W'(MAP_LEN), full: 1'b1};
                acc_next           = MAP_LEN'(merged >> MAP_LEN);
                acc_cnt_next       = CNT_W'(total - SUM_W'(MAP_LEN));
                flush_pending_next = flush_i && (total != SUM_W'(MAP_LEN));
            end else if (flush_i && total != '0) begin
                if (out_free) begin
                    load         = 1'b1;
                    load_map     = '{map: merged[MAP_LEN-1:0], cnt: CNT_W'(total), full: 1'b0};
                    acc_next     = '0;
                    acc_cnt_next = '0;
                end else begin
                    // Output still held: keep the partial map and emit it once the slot frees.
                    acc_next           = merged[MAP_LEN-1:0];
                    acc_cnt_next       = CNT_W'(total);
                    flush_pending_next = 1'b1;
                end
            end else begin
                acc_next     = merged[MAP_LEN-1:0];
                acc_cnt_next = CNT_W'(total);
            end
            if (flush_i) begin
                overflow_next = 1'b0;
            end
        end else begin
            if ((|valid_i) || flush_i) begin
                overflow_next = 1'b1;
            end
            if (flush_pending_reg && out_free) begin
                load               = 1'b1;
                load_map           = '{map: acc_reg, cnt: acc_cnt_reg, full: 1'b0};
                acc_next           = '0;
                acc_cnt_next       = '0;
                flush_pending_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_reg           <= '0;
            acc_cnt_reg       <= '0;
            flush_pending_reg <= 1'b0;
            overflow_reg      <= 1'b0;
            out_reg           <= '0;
            out_valid_reg     <= 1'b0;
        end else begin
            acc_reg           <= acc_next;
            acc_cnt_reg       <= acc_cnt_next;
            flush_pending_reg <= flush_pending_next;
            overflow_reg      <= overflow_next;
            if (load) begin
                out_reg       <= load_map;
                out_valid_reg <= 1'b1;
            end else if (map_ready_i) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign ready_o     = ready;
    assign map_o       = out_reg.map;
    assign cnt_o       = out_reg.cnt;
    assign full_o      = out_reg.full;
    assign map_valid_o = out_valid_reg;
    assign overflow_o  = overflow_reg;

endmodule
